decoder_3to8: RTL and testbench

- Registered 3-to-8 one-hot binary decoder.
- Converts a 3-bit select code A into an 8-bit one-hot word Y1, registered on clk with a synchronous active-high reset.
- Used as a select/enable fan-out stage: address-to-chip-select, mux-control generation.
- Small, self-contained leaf block with no handshake beyond an enable.

---
 rtl/decoder_pkg.sv | 15 +
 rtl/decoder_3to8_core.sv | 19 +
 rtl/decoder_3to8.sv | 91 +++++++++
 tb/tb_decoder_3to8.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants, types and helpers for the registered 3-to-8 one-hot decoder.
package decoder_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
  // Index 0 is the leftmost bit, so code 0 lights the MSB position.
  typedef logic [0:OUT_W-1] onehot_t;

  function automatic onehot_t onehot_inactive(input bit active_low);
    return active_low ? onehot_t'(8'hFF) : onehot_t'(8'h00);
  endfunction

endpackage

// File: rtl/decoder_3to8_core.sv
// Combinational 3-bit code to one-hot word, with selectable output polarity.
module decoder_3to8_core
  import decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  sel_t    a_i,
  output onehot_t y_o
);

  onehot_t hot;

  // Shifting from the leftmost position makes bit [a_i] of the [0:7] word active.
  always_comb begin
    hot = onehot_t'(8'h80 >> a_i);
    y_o = ACTIVE_LOW ? ~hot : hot;
  end

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with enable, valid flag and optional output register bypass.
// Optional change-flag output CHG is built when DECODER_3TO8_CHANGE_FLAG_EN is defined.
module decoder_3to8
  import decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit REG_OUT    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic [2:0] A,
  output logic [0:7] Y1,
`ifdef DECODER_3TO8_CHANGE_FLAG_EN
  output logic       CHG,
`endif
  output logic       VLD
);

  localparam onehot_t INACTIVE = onehot_inactive(ACTIVE_LOW);

  onehot_t dec;
  logic    vld_q, vld_d;

  decoder_3to8_core #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_core (
    .a_i(A),
    .y_o(dec)
  );

  // EN acts as a one-sided valid: each enabled edge loads a fresh code; VLD stays
  // high until reset, and there is no back-pressure.
  always_comb begin
    vld_d = vld_q;
    if (EN) vld_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end

  assign VLD = vld_q;

  if (REG_OUT) begin : g_reg
    onehot_t y_q, y_d;

    always_comb begin
      y_d = y_q;
      if (EN) y_d = dec;
    end

    always_ff @(posedge clk) begin
      if (rst) y_q <= INACTIVE;
      else     y_q <= y_d;
    end

    assign Y1 = y_q;
  end else begin : g_comb
    assign Y1 = vld_q ? dec : INACTIVE;
  end

`ifdef DECODER_3TO8_CHANGE_FLAG_EN
  sel_t last_q, last_d;
  logic chg_q, chg_d;

  // !vld_q marks the first decode after reset, which always counts as a change.
  always_comb begin
    last_d = last_q;
    chg_d  = 1'b0;
    if (EN) begin
      last_d = A;
      chg_d  = !vld_q || (A != last_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      chg_q  <= chg_d;
    end
  end

  assign CHG = chg_q;
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed self-checking bench: default build (registered, active-high) plus an
// active-low combinational-output instance driven by the same inputs.
module tb_decoder_3to8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] a;
  logic [0:7] y1, y1_al;
  logic       vld, vld_al;
`ifdef DECODER_3TO8_CHANGE_FLAG_EN
  logic       chg, chg_al;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] sweep_exp [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  always #5 clk = ~clk;

  decoder_3to8 dut (
    .clk(clk), .rst(rst), .EN(en), .A(a), .Y1(y1),
`ifdef DECODER_3TO8_CHANGE_FLAG_EN
    .CHG(chg),
`endif
    .VLD(vld)
  );

  decoder_3to8 #(.ACTIVE_LOW(1'b1), .REG_OUT(1'b0)) dut_al (
    .clk(clk), .rst(rst), .EN(en), .A(a), .Y1(y1_al),
`ifdef DECODER_3TO8_CHANGE_FLAG_EN
    .CHG(chg_al),
`endif
    .VLD(vld_al)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset with an active code and enable present.
    rst = 1'b1; en = 1'b1; a = 3'b101;
    tick(); tick();
    chk("rst_y1", y1, 8'h00);
    chk("rst_vld", {7'b0, vld}, 8'h00);
    chk("rst_y1_al", y1_al, 8'hFF);
    chk("rst_vld_al", {7'b0, vld_al}, 8'h00);
`ifdef DECODER_3TO8_CHANGE_FLAG_EN
    chk("rst_chg", {7'b0, chg}, 8'h00);
`endif

    // Sweep every code, each held 5 cycles.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = i[2:0];
      tick();
      chk($sformatf("sweep_y1_%0d", i), y1, sweep_exp[i]);
      chk($sformatf("sweep_vld_%0d", i), {7'b0, vld}, 8'h01);
      chk($sformatf("sweep_y1_al_%0d", i), y1_al, ~sweep_exp[i]);
`ifdef DECODER_3TO8_CHANGE_FLAG_EN
      chk($sformatf("sweep_chg_%0d", i), {7'b0, chg}, 8'h01);
`endif
      for (int k = 0; k < 4; k++) begin
        tick();
        chk($sformatf("sweep_hold_%0d_%0d", i, k), y1, sweep_exp[i]);
`ifdef DECODER_3TO8_CHANGE_FLAG_EN
        chk($sformatf("sweep_chg_rep_%0d_%0d", i, k), {7'b0, chg}, 8'h00);
`endif
      end
    end

    // Enable hold: A is ignored by the registered output while EN is low.
    a = 3'd3;
    tick();
    chk("en_load3", y1, 8'h10);
    en = 1'b0; a = 3'd6;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("en_hold_%0d", k), y1, 8'h10);
      chk($sformatf("en_hold_vld_%0d", k), {7'b0, vld}, 8'h01);
      chk($sformatf("en_hold_al_%0d", k), y1_al, 8'hFD);
`ifdef DECODER_3TO8_CHANGE_FLAG_EN
      chk($sformatf("en_hold_chg_%0d", k), {7'b0, chg}, 8'h00);
`endif
    end
    en = 1'b1;
    tick();
    chk("en_resume", y1, 8'h02);

    // Reset has priority mid-operation.
    a = 3'd2;
    tick();
    chk("rp_pre", y1, 8'h20);
    rst = 1'b1;
    tick();
    chk("rp_y1", y1, 8'h00);
    chk("rp_vld", {7'b0, vld}, 8'h00);
    chk("rp_y1_al", y1_al, 8'hFF);
    rst = 1'b0;
    tick();
    chk("rp_after", y1, 8'h20);
    chk("rp_after_vld", {7'b0, vld}, 8'h01);
`ifdef DECODER_3TO8_CHANGE_FLAG_EN
    chk("rp_after_chg", {7'b0, chg}, 8'h01);
`endif

    // Reset wins even with EN low.
    rst = 1'b1; en = 1'b0;
    tick();
    chk("rp_en0_y1", y1, 8'h00);
    chk("rp_en0_vld", {7'b0, vld}, 8'h00);
    rst = 1'b0;
    tick();
    chk("en0_after_rst_y1", y1, 8'h00);
    chk("en0_after_rst_al", y1_al, 8'hFF);
    en = 1'b1;

    // Back-to-back codes, one per cycle.
    a = 3'd0; tick(); chk("b2b_0", y1, 8'h80);
    a = 3'd7; tick(); chk("b2b_7", y1, 8'h01);
    a = 3'd1; tick(); chk("b2b_1", y1, 8'h40);
    a = 3'd6; tick(); chk("b2b_6", y1, 8'h02);
    chk("b2b_6_al", y1_al, 8'hFD);

`ifdef DECODER_3TO8_CHANGE_FLAG_EN
    // Change flag: 4,4,5 after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a = 3'd4; tick(); chk("chg_4a", {7'b0, chg}, 8'h01);
    a = 3'd4; tick(); chk("chg_4b", {7'b0, chg}, 8'h00);
    a = 3'd5; tick(); chk("chg_5", {7'b0, chg}, 8'h01);
    chk("chg_5_y1", y1, 8'h04);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
